serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor_pkg.sv | 12 +
 rtl/serial_subtractor_if.sv | 27 ++
 rtl/serial_subtractor_cell.sv | 16 +
 rtl/serial_subtractor.sv | 99 +++++++++
 tb/tb_serial_subtractor.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared state encoding and default width for the serial subtractor
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - request/result bundle between a requester and the serial subtractor
interface serial_subtractor_if #(
  parameter int WIDTH = 8
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bor;
  logic             ovf;

  // Requester drives operands and start, observes status and result
  modport master (
    output start, a, b,
    input  busy, done, diff, bor, ovf
  );

  // Subtractor consumes operands and start, produces status and result
  modport slave (
    input  start, a, b,
    output busy, done, diff, bor, ovf
  );

endinterface

// File: rtl/serial_subtractor_cell.sv
// rtl/serial_subtractor_cell.sv - 1-bit full-subtract cell used once per RUN cycle
module full_sub_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  // Difference bit and borrow-out of x - y - bin
  always_comb begin
    d    = x ^ y ^ bin;
    bout = (~x & y) | (~x & bin) | (y & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a-b, LSB first, one bit per clock
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_subtractor_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] diff_r;
  logic [CW-1:0]    cnt;
  logic             borrow;
  logic             a_msb;
  logic             b_msb;
  logic             busy_r;
  logic             done_r;
  logic             bor_r;
  logic             ovf_r;
  logic             d;
  logic             bout;

  full_sub_cell u_cell (
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .bin  (borrow),
    .d    (d),
    .bout (bout)
  );

  // Control FSM plus datapath: operand capture, serial shift, result/flag registration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      diff_r <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      bor_r  <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            // Operand sign bits are gone after shifting, so keep them for the overflow flag
            a_msb  <= bus.a[WIDTH-1];
            b_msb  <= bus.b[WIDTH-1];
            borrow <= 1'b0;
            cnt    <= '0;
            busy_r <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          diff_r <= {d, diff_r[WIDTH-1:1]};
          borrow <= bout;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= DONE;
          end
        end
        DONE: begin
          done_r <= 1'b1;
          bor_r  <= borrow;
          ovf_r  <= (a_msb != b_msb) && (diff_r[WIDTH-1] != a_msb);
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.diff = diff_r;
  assign bus.bor  = bor_r;
  assign bus.ovf  = ovf_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed and exhaustive checks of the serial subtractor
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  serial_subtractor_if #(.WIDTH(8)) b8 ();
  serial_subtractor_if #(.WIDTH(4)) b4 ();

  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
  serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       bor;
    logic       ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Caller is #1 after an edge with the DUT idle; returns #1 after the done edge
  task automatic op8(input logic [7:0] ai, input logic [7:0] bi, output int lat);
    b8.start = 1'b1;
    b8.a = ai;
    b8.b = bi;
    @(posedge clk); #1;
    b8.start = 1'b0;
    b8.a = ~ai;
    b8.b = ai ^ 8'h5A;
    lat = 0;
    while (!b8.done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic op4(input logic [3:0] ai, input logic [3:0] bi, output int lat, output int busy_cnt);
    b4.start = 1'b1;
    b4.a = ai;
    b4.b = bi;
    @(posedge clk); #1;
    b4.start = 1'b0;
    b4.a = ~ai;
    b4.b = ~bi;
    lat = 0;
    busy_cnt = b4.busy ? 1 : 0;
    while (!b4.done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (b4.busy) busy_cnt++;
    end
  endtask

  initial begin
    int lat;
    int busy_cnt;
    int dones;
    int first_done;
    logic [7:0] diff_at_done;
    logic       bor_at_done;

    vecs[0] = '{8'h35, 8'h12, 8'h23, 1'b0, 1'b0};
    vecs[1] = '{8'h12, 8'h35, 8'hDD, 1'b1, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vecs[3] = '{8'h42, 8'h42, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0};
    vecs[5] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
    vecs[6] = '{8'h01, 8'h80, 8'h81, 1'b1, 1'b1};
    vecs[7] = '{8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0};

    b8.start = 1'b0; b8.a = '0; b8.b = '0;
    b4.start = 1'b0; b4.a = '0; b4.b = '0;

    #2 rst_n = 1'b0;
    #1;
    check("reset_busy", 32'(b8.busy), 32'd0);
    check("reset_done", 32'(b8.done), 32'd0);
    check("reset_diff", 32'(b8.diff), 32'd0);
    check("reset_bor",  32'(b8.bor),  32'd0);
    check("reset_ovf",  32'(b8.ovf),  32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Vectors are back-to-back: each start is driven in the IDLE cycle following done
    for (int i = 0; i < 8; i++) begin
      op8(vecs[i].a, vecs[i].b, lat);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'd9);
      check($sformatf("v%0d_diff", i), 32'(b8.diff), 32'(vecs[i].diff));
      check($sformatf("v%0d_bor", i), 32'(b8.bor), 32'(vecs[i].bor));
      check($sformatf("v%0d_ovf", i), 32'(b8.ovf), 32'(vecs[i].ovf));
      check($sformatf("v%0d_busy_at_done", i), 32'(b8.busy), 32'd0);
    end

    // Result holds through IDLE and done is a single-cycle pulse
    repeat (3) @(posedge clk);
    #1;
    check("hold_done", 32'(b8.done), 32'd0);
    check("hold_diff", 32'(b8.diff), 32'hFE);
    check("hold_busy", 32'(b8.busy), 32'd0);

    // Start re-pulsed during RUN must be ignored
    dones = 0; first_done = -1; diff_at_done = '0; bor_at_done = 1'b1;
    b8.start = 1'b1; b8.a = 8'h10; b8.b = 8'h01;
    @(posedge clk); #1;
    b8.start = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      if (k == 3) begin b8.start = 1'b1; b8.a = 8'hFF; b8.b = 8'hFF; end
      if (k == 4) b8.start = 1'b0;
      @(posedge clk); #1;
      if (b8.done) begin
        dones++;
        if (first_done < 0) begin
          first_done = k;
          diff_at_done = b8.diff;
          bor_at_done = b8.bor;
        end
      end
    end
    check("restart_done_count", 32'(dones), 32'd1);
    check("restart_latency", 32'(first_done), 32'd9);
    check("restart_diff", 32'(diff_at_done), 32'h0F);
    check("restart_bor", 32'(bor_at_done), 32'd0);

    // Leave nonzero flags so the reset clear is visible
    op8(8'h01, 8'h80, lat);
    check("pre_reset_ovf", 32'(b8.ovf), 32'd1);

    // Reset in the 4th RUN cycle aborts the operation immediately
    b8.start = 1'b1; b8.a = 8'h55; b8.b = 8'h11;
    @(posedge clk); #1;
    b8.start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(b8.busy), 32'd0);
    check("abort_done", 32'(b8.done), 32'd0);
    check("abort_diff", 32'(b8.diff), 32'd0);
    check("abort_bor",  32'(b8.bor),  32'd0);
    check("abort_ovf",  32'(b8.ovf),  32'd0);
    dones = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (b8.done) dones++;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      if (b8.done) dones++;
    end
    check("abort_no_done", 32'(dones), 32'd0);
    op8(8'h00, 8'hFF, lat);
    check("after_abort_latency", 32'(lat), 32'd9);
    check("after_abort_diff", 32'(b8.diff), 32'h01);
    check("after_abort_bor", 32'(b8.bor), 32'd1);

    // Exhaustive 4-bit sweep, back-to-back, against an independent signed/unsigned model
    for (int i = 0; i < 256; i++) begin
      logic [3:0] ai;
      logic [3:0] bi;
      int         sres;
      logic [3:0] exp_diff;
      logic       exp_bor;
      logic       exp_ovf;
      ai = 4'(i >> 4);
      bi = 4'(i);
      exp_diff = 4'((32'(ai) - 32'(bi)) & 32'hF);
      exp_bor = (ai < bi);
      sres = int'($signed(ai)) - int'($signed(bi));
      exp_ovf = (sres > 7) || (sres < -8);
      op4(ai, bi, lat, busy_cnt);
      check($sformatf("w4_%0h_%0h_latency", ai, bi), 32'(lat), 32'd5);
      check($sformatf("w4_%0h_%0h_busy", ai, bi), 32'(busy_cnt), 32'd5);
      check($sformatf("w4_%0h_%0h_diff", ai, bi), 32'(b4.diff), 32'(exp_diff));
      check($sformatf("w4_%0h_%0h_bor", ai, bi), 32'(b4.bor), 32'(exp_bor));
      check($sformatf("w4_%0h_%0h_ovf", ai, bi), 32'(b4.ovf), 32'(exp_ovf));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
